// File: rtl/lcd_update_arbiter.sv
// Round-robin arbiter sharing one 4-phase LCD update port among NREQ requesters.
// Optional ack-wait timeout is enabled by defining LCD_ARB_TIMEOUT_EN.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | no transfer; pick next requester once LCDAck is low
// WAIT_ACK | LCDUpdate high with frozen data, waiting for LCDAck
// RELEASE  | transfer finished, waiting for LCDAck to return low
module lcd_update_arbiter #(
    parameter int NREQ    = 3,
    parameter int DW      = 10,
    parameter int TIMEOUT = 1023
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NREQ-1:0]    req_i,
    input  logic [NREQ*DW-1:0] req_data_i,
    output logic [NREQ-1:0]    grant_o,
    output logic               lcd_update_o,
    output logic [DW-1:0]      lcd_data_o,
    input  logic               lcd_ack_i,
    output logic               busy_o,
    output logic               timeout_err_o
);

    localparam int PW = $clog2(NREQ);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_WAIT_ACK = 2'd1;
    localparam logic [1:0] S_RELEASE  = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   sel_q, sel_d;
    logic            lcd_update_q, lcd_update_d;
    logic [DW-1:0]   lcd_data_q, lcd_data_d;
    logic [NREQ-1:0] grant_q, grant_d;

    logic            win_found;
    logic [PW-1:0]   win_idx;
    logic            finish;

    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int offs);
        int sum;
        sum = int'(base) + offs;
        if (sum >= NREQ) sum = sum - NREQ;
        return PW'(sum);
    endfunction

    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_i[wrap_add(ptr_q, k)]) begin
                win_found = 1'b1;
                win_idx   = wrap_add(ptr_q, k);
            end
        end
    end

`ifdef LCD_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_err_q, timeout_err_d;
`endif

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        sel_d        = sel_q;
        lcd_update_d = lcd_update_q;
        lcd_data_d   = lcd_data_q;
        grant_d      = '0;
        finish       = 1'b0;
`ifdef LCD_ARB_TIMEOUT_EN
        cnt_d         = cnt_q;
        timeout_err_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (win_found && !lcd_ack_i) begin
                    lcd_data_d   = req_data_i[win_idx*DW +: DW];
                    lcd_update_d = 1'b1;
                    sel_d        = win_idx;
                    state_d      = S_WAIT_ACK;
`ifdef LCD_ARB_TIMEOUT_EN
                    cnt_d        = '0;
`endif
                end
            end
            S_WAIT_ACK: begin
                if (lcd_ack_i) begin
                    finish = 1'b1;
`ifdef LCD_ARB_TIMEOUT_EN
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    finish        = 1'b1;
                    timeout_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
`endif
                end
            end
            S_RELEASE: begin
                if (!lcd_ack_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (finish) begin
            lcd_update_d   = 1'b0;
            grant_d[sel_q] = 1'b1;
            ptr_d          = wrap_add(sel_q, 1);
            state_d        = S_RELEASE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            sel_q        <= '0;
            lcd_update_q <= 1'b0;
            lcd_data_q   <= '0;
            grant_q      <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            sel_q        <= sel_d;
            lcd_update_q <= lcd_update_d;
            lcd_data_q   <= lcd_data_d;
            grant_q      <= grant_d;
        end
    end

`ifdef LCD_ARB_TIMEOUT_EN
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err_o = timeout_err_q;
`else
    // TIMEOUT has no effect when the timeout feature is not built in.
    assign timeout_err_o = 1'b0 & (TIMEOUT > 0);
`endif

    assign grant_o      = grant_q;
    assign lcd_update_o = lcd_update_q;
    assign lcd_data_o   = lcd_data_q;
    assign busy_o       = (state_q != S_IDLE);

endmodule
